serial_gp_adder_ctrl: RTL and testbench
=======================================

# serial_gp_adder_ctrl

Sequencer and arbiter for a single shared GP full-adder cell. It performs a WIDTH-bit addition bit-serially, LSB first, over WIDTH cycles. Two requesters share the cell through a grant handshake. The block returns Sum, Cout and the group generate/propagate pair, so results can feed a carry-lookahead tree in the lab CLA datapath.

## Interface
- WIDTH, 8, operand width in bits (≥2).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- Req0 / Req1  in  1  operation request from requester 0 / 1.
- A0, B0 / A1, B1  in  WIDTH  operands of requester 0 / 1.
- Cin0 / Cin1  in  1  carry-in of requester 0 / 1.
- Gnt  out  2  one-hot grant; bit n high means requester n is accepted at this edge.
- Busy  out  1  high whenever state ≠ IDLE.
- Valid  out  1  result available.
- Owner  out  1  index of requester that owns the current/last result.
- Sum  out  WIDTH  sum.
- Cout  out  1  carry out of bit WIDTH-1.
- G  out  1  group generate (carry-out with carry-in forced 0).
- P  out  1  group propagate (AND of all A[i]^B[i]).
- Ack  in  1  consumer accepts the result; only honoured while Valid = 1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Gnt is combinational from the arbiter.
  - If any Req is high, the winner's A, B and Cin are latched, and Owner is set to the winner.
  - The bit counter is cleared, and the state moves to RUN.
- RUN, per edge at bit i:
  - p = a[i]^b[i] and g = a[i]&b[i].
  - s[i] = p^c and c ← g|(p&c).
  - gc ← g|(p&gc), with gc starting at 0.
  - pa ← pa&p, with pa starting at 1.
  - After bit WIDTH-1, Sum, Cout = c, G = gc and P = pa are registered, Valid is set, and the state moves to DONE.
- DONE:
  - Outputs are held.
  - Ack moves the state to IDLE and clears Valid.
  - Sum, Cout, G, P and Owner keep their last values until the next completion.
- Gnt is 0 outside IDLE. A requester holds Req and its operands stable until it sees its Gnt bit.
- Arbitration: see Configuration. Requests not granted stay pending; no queueing inside the block.
- Arithmetic is modulo 2^WIDTH; the overflow bit is Cout.

## Timing
- Reset values: Gnt=0, Busy=0, Valid=0, Owner=0, Sum=0, Cout=0, G=0, P=0; internal round-robin pointer selects requester 0 first.
- Acceptance edge e0 (IDLE, Gnt≠0). Bits are processed on edges e1..eWIDTH.
- Valid rises after edge eWIDTH, so latency is WIDTH cycles from acceptance.
- Ack high with Valid high at edge eA: Valid is low after eA and the state is IDLE. A new grant is possible in the cycle after eA.
- Minimum spacing between back-to-back operations is WIDTH+2 edges.
- Ack while Valid=0 is ignored.
- Req changes during RUN/DONE have no effect on the running operation.
- rst_n low at any edge:
  - Forces IDLE, all outputs to reset values, and discards any operation in flight. No Valid is produced for it.
  - Reset has priority over Ack and Req at the same edge.
- Simultaneous Req0 and Req1 in IDLE are resolved by the arbiter in the same cycle; exactly one Gnt bit is high.

## Configuration
- ROUND_ROBIN_EN defined:
  - Round-robin arbitration; on a tie, the requester not granted last wins.
  - A pointer register updates on every grant.
  - After reset, requester 0 wins the first tie.
- Not defined:
  - Fixed priority; Req0 always beats Req1.
  - No pointer register.
  - Req1 can starve.

## Test plan
- WIDTH=8, Req0, A0=0x5A, B0=0x3C, Cin0=0 -> Gnt=01. Valid 8 cycles after acceptance with Sum=0x96, Cout=0, G=0, P=0, Owner=0.
- Req1, A1=0xFF, B1=0x01, Cin1=0 -> Gnt=10, Sum=0x00, Cout=1, G=1, P=0, Owner=1.
- Req0, A0=0xF0, B0=0x0F, Cin0=1 -> Sum=0x00, Cout=1, G=0, P=1.
- Req0 and Req1 held high, Ack pulsed on each Valid:
  - With ROUND_ROBIN_EN, the grant sequence is 01, 10, 01, 10.
  - Without it, the sequence is 01, 01, 01.
- rst_n low for 1 cycle at the 4th RUN edge -> Busy=0 and Valid=0 next cycle, no Valid for the aborted op, and the next op (0x01+0x01) gives Sum=0x02.
- Ack held low 20 cycles after Valid with Req1 pending -> Valid, Sum, Owner stable, Gnt=00 throughout; Req1 granted in the cycle after Ack.

Source files
------------

// File: rtl/serial_gp_adder_ctrl_if.sv
// Port bundle for serial_gp_adder_ctrl: requests, operands, grant, result and consumer ack.
// The width is set by WIDTH and must match the WIDTH of the attached controller.
interface serial_gp_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             Req0;
   logic             Req1;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] B0;
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] B1;
   logic             Cin0;
   logic             Cin1;
   logic [1:0]       Gnt;
   logic             Busy;
   logic             Valid;
   logic             Owner;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             G;
   logic             P;
   logic             Ack;

   // Handshakes:
   // - Request side: requester n keeps ReqN, An, Bn and CinN stable until Gnt[n] is seen
   //   high at a rising edge. That edge is the transfer.
   // - Result side: Valid stays high with stable results until a rising edge with Ack=1.
   //   That edge is the transfer. Ack is ignored while Valid=0.
   modport master (
      output Req0, Req1, A0, B0, A1, B1, Cin0, Cin1, Ack,
      input  Gnt, Busy, Valid, Owner, Sum, Cout, G, P
   );

   modport slave (
      input  Req0, Req1, A0, B0, A1, B1, Cin0, Cin1, Ack,
      output Gnt, Busy, Valid, Owner, Sum, Cout, G, P
   );
endinterface

// File: rtl/serial_gp_adder_ctrl.sv
// Two-requester arbiter and bit-serial sequencer around one shared GP full-adder cell.
// Optional macro ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module serial_gp_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_gp_adder_ctrl_if.slave bus,
   output logic [1:0]            state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] sum_sh;
   logic [CNT_W-1:0] bit_cnt;
   logic             c;
   logic             gc;
   logic             pa;

   logic             win0;
   logic             win1;
   logic             idle;
   logic             accept;

   logic             bit_p;
   logic             bit_g;
   logic             bit_s;
   logic             c_nxt;
   logic             gc_nxt;
   logic             pa_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic             last_bit;

`ifdef ROUND_ROBIN_EN
   // rr_ptr names the requester that wins the next tie.
   logic rr_ptr;
`endif

   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
`ifdef ROUND_ROBIN_EN
      if (bus.Req0 && bus.Req1) begin
         win0 = ~rr_ptr;
         win1 = rr_ptr;
      end else begin
         win0 = bus.Req0;
         win1 = bus.Req1;
      end
`else
      win0 = bus.Req0;
      win1 = bus.Req1 & ~bus.Req0;
`endif
   end

   // Grant is suppressed while reset is asserted so no requester sees a phantom acceptance.
   assign idle     = (state == ST_IDLE) && rst_n;
   assign accept   = idle && (bus.Req0 || bus.Req1);
   assign bus.Gnt  = idle ? {win1, win0} : 2'b00;
   assign bus.Busy = (state != ST_IDLE);

   always_comb begin
      bit_p    = a_sh[0] ^ b_sh[0];
      bit_g    = a_sh[0] & b_sh[0];
      bit_s    = bit_p ^ c;
      c_nxt    = bit_g | (bit_p & c);
      gc_nxt   = bit_g | (bit_p & gc);
      pa_nxt   = pa & bit_p;
      sum_nxt  = {bit_s, sum_sh};
      last_bit = (bit_cnt == LAST_BIT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         bit_cnt   <= '0;
         c         <= 1'b0;
         gc        <= 1'b0;
         pa        <= 1'b1;
         bus.Valid <= 1'b0;
         bus.Owner <= 1'b0;
         bus.Sum   <= '0;
         bus.Cout  <= 1'b0;
         bus.G     <= 1'b0;
         bus.P     <= 1'b0;
`ifdef ROUND_ROBIN_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (win1) begin
                     a_sh      <= bus.A1;
                     b_sh      <= bus.B1;
                     c         <= bus.Cin1;
                     bus.Owner <= 1'b1;
                  end else begin
                     a_sh      <= bus.A0;
                     b_sh      <= bus.B0;
                     c         <= bus.Cin0;
                     bus.Owner <= 1'b0;
                  end
                  gc      <= 1'b0;
                  pa      <= 1'b1;
                  bit_cnt <= '0;
                  state   <= ST_RUN;
`ifdef ROUND_ROBIN_EN
                  rr_ptr  <= win0;
`endif
               end
            end
            ST_RUN: begin
               // Operands shift right so the cell always sees the current bit at index 0.
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               c       <= c_nxt;
               gc      <= gc_nxt;
               pa      <= pa_nxt;
               sum_sh  <= sum_nxt[WIDTH-1:1];
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) begin
                  bus.Sum   <= sum_nxt;
                  bus.Cout  <= c_nxt;
                  bus.G     <= gc_nxt;
                  bus.P     <= pa_nxt;
                  bus.Valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.Ack && bus.Valid) begin
                  bus.Valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_gp_adder_ctrl.sv
// Directed bench for serial_gp_adder_ctrl; builds with or without ROUND_ROBIN_EN.
module tb_serial_gp_adder_ctrl;
   localparam int WIDTH = 8;

   logic       clk;
   logic       rst_n;
   logic [1:0] state;
   int         checks;
   int         errors;

   serial_gp_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_gp_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .state (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_gnt"},   32'(bus.Gnt),   32'd0);
      check({tag, "_busy"},  32'(bus.Busy),  32'd0);
      check({tag, "_valid"}, 32'(bus.Valid), 32'd0);
      check({tag, "_owner"}, 32'(bus.Owner), 32'd0);
      check({tag, "_sum"},   32'(bus.Sum),   32'd0);
      check({tag, "_cout"},  32'(bus.Cout),  32'd0);
      check({tag, "_g"},     32'(bus.G),     32'd0);
      check({tag, "_p"},     32'(bus.P),     32'd0);
   endtask

   // Steps from the acceptance edge until Valid; optionally pulses Ack while Valid is low.
   task automatic wait_valid(input bit ack_mid);
      int n;
      n = 0;
      while (!bus.Valid && n < 40) begin
         bus.Ack = ack_mid && (n == 2);
         step();
         n++;
      end
      bus.Ack = 1'b0;
      check("latency", 32'(n), 32'(WIDTH));
   endtask

   task automatic finish_op(input logic [7:0] e_sum, input logic e_cout, input logic e_g,
                            input logic e_p, input logic e_owner);
      check("sum",        32'(bus.Sum),   32'(e_sum));
      check("cout",       32'(bus.Cout),  32'(e_cout));
      check("g",          32'(bus.G),     32'(e_g));
      check("p",          32'(bus.P),     32'(e_p));
      check("owner",      32'(bus.Owner), 32'(e_owner));
      check("done_busy",  32'(bus.Busy),  32'd1);
      check("done_gnt",   32'(bus.Gnt),   32'd0);
      bus.Ack = 1'b1;
      step();
      bus.Ack = 1'b0;
      check("ack_valid",  32'(bus.Valid), 32'd0);
      check("ack_busy",   32'(bus.Busy),  32'd0);
   endtask

   task automatic do_op(input bit idx, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [1:0] e_gnt, input logic [7:0] e_sum, input logic e_cout,
                        input logic e_g, input logic e_p, input bit ack_mid);
      if (idx) begin
         bus.A1 = a; bus.B1 = b; bus.Cin1 = cin; bus.Req1 = 1'b1;
      end else begin
         bus.A0 = a; bus.B0 = b; bus.Cin0 = cin; bus.Req0 = 1'b1;
      end
      #1;
      check("gnt", 32'(bus.Gnt), 32'(e_gnt));
      step();
      bus.Req0 = 1'b0;
      bus.Req1 = 1'b0;
      check("run_busy", 32'(bus.Busy), 32'd1);
      check("run_gnt",  32'(bus.Gnt),  32'd0);
      wait_valid(ack_mid);
      finish_op(e_sum, e_cout, e_g, e_p, idx);
   endtask

   initial begin
      logic [1:0] exp_seq [4];
      int         n_rr;
      bit         seen_valid;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.Req0 = 1'b0; bus.Req1 = 1'b0;
      bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
      bus.Cin0 = 1'b0; bus.Cin1 = 1'b0; bus.Ack = 1'b0;

      step();
      step();
      check_reset_vals("reset");
      rst_n = 1'b1;
      step();

      do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 2'b01, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
      do_op(1'b1, 8'hFF, 8'h01, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      do_op(1'b0, 8'hF0, 8'h0F, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      // Reset between tests clears held results and the round-robin pointer.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_vals("rst_pulse");

`ifdef ROUND_ROBIN_EN
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      n_rr = 4;
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
      n_rr = 3;
`endif
      bus.A0 = 8'h11; bus.B0 = 8'h22; bus.Cin0 = 1'b0;
      bus.A1 = 8'h40; bus.B1 = 8'h05; bus.Cin1 = 1'b1;
      bus.Req0 = 1'b1;
      bus.Req1 = 1'b1;
      for (int k = 0; k < n_rr; k++) begin
         #1;
         check("tie_gnt", 32'(bus.Gnt), 32'(exp_seq[k]));
         step();
         wait_valid(1'b0);
         if (exp_seq[k] == 2'b10) finish_op(8'h46, 1'b0, 1'b0, 1'b0, 1'b1);
         else                     finish_op(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus.Req0 = 1'b0;
      bus.Req1 = 1'b0;
      step();

      // Abort: reset lands on the 4th bit edge.
      bus.A0 = 8'h12; bus.B0 = 8'h34; bus.Cin0 = 1'b0; bus.Req0 = 1'b1;
      #1;
      check("abort_gnt", 32'(bus.Gnt), 32'd1);
      step();
      bus.Req0 = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_vals("abort");
      seen_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (bus.Valid) seen_valid = 1'b1;
      end
      check("abort_no_valid", 32'(seen_valid), 32'd0);
      do_op(1'b0, 8'h01, 8'h01, 1'b0, 2'b01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

      // Consumer stalls with Valid high while requester 1 waits.
      bus.A0 = 8'h10; bus.B0 = 8'h20; bus.Cin0 = 1'b0; bus.Req0 = 1'b1;
      #1;
      check("hold_gnt0", 32'(bus.Gnt), 32'd1);
      step();
      bus.Req0 = 1'b0;
      wait_valid(1'b0);
      bus.A1 = 8'h80; bus.B1 = 8'h80; bus.Cin1 = 1'b1; bus.Req1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         check("hold_valid", 32'(bus.Valid), 32'd1);
         check("hold_sum",   32'(bus.Sum),   32'h30);
         check("hold_owner", 32'(bus.Owner), 32'd0);
         check("hold_gnt",   32'(bus.Gnt),   32'd0);
         step();
      end
      bus.Ack = 1'b1;
      step();
      bus.Ack = 1'b0;
      check("hold_ack_valid", 32'(bus.Valid), 32'd0);
      check("hold_gnt1",      32'(bus.Gnt),   32'd2);
      step();
      bus.Req1 = 1'b0;
      wait_valid(1'b0);
      finish_op(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
